// File: rtl/rename_stage_n.sv
// N-wide register-rename stage: RAT plus circular free list, with intra-group bypass,
// all-or-nothing group acceptance and free-list recycling on retire.
module rename_stage_n #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned PC_W      = 8,
    localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS,
    localparam int unsigned CNT_W    = $clog2(FL_DEPTH + 1),
    localparam int unsigned PTR_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        in_valid,
    input  logic [WIDTH*32-1:0]     in_instr,
    input  logic [WIDTH*PC_W-1:0]   in_pc,
    input  logic [WIDTH*5-1:0]      in_rd,
    input  logic [WIDTH*5-1:0]      in_rs1,
    input  logic [WIDTH*5-1:0]      in_rs2,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_valid,
    output logic [WIDTH*32-1:0]     out_instr,
    output logic [WIDTH*PC_W-1:0]   out_pc,
    output logic [WIDTH*PREG_W-1:0] out_pd,
    output logic [WIDTH*PREG_W-1:0] out_ps1,
    output logic [WIDTH*PREG_W-1:0] out_ps2,
    output logic [WIDTH*PREG_W-1:0] out_old_pd,
    input  logic                    out_ready,
    input  logic [WIDTH-1:0]        rt_valid,
    input  logic [WIDTH*PREG_W-1:0] rt_preg,
    output logic [CNT_W-1:0]        free_count
);

    logic [PREG_W-1:0]       r_rat [ARCH_REGS];
    logic [PREG_W-1:0]       r_fl  [FL_DEPTH];
    logic [PTR_W-1:0]        r_head, r_tail;
    logic [CNT_W-1:0]        r_count;
    logic [WIDTH-1:0]        r_out_valid;
    logic [WIDTH*32-1:0]     r_out_instr;
    logic [WIDTH*PC_W-1:0]   r_out_pc;
    logic [WIDTH*PREG_W-1:0] r_out_pd, r_out_ps1, r_out_ps2, r_out_old_pd;

    logic [WIDTH-1:0]        w_alloc;
    int unsigned             w_n_alloc, w_n_pop, w_n_push;
    logic                    w_accept;
    logic [PREG_W-1:0]       w_pd     [WIDTH];
    logic [PREG_W-1:0]       w_ps1    [WIDTH];
    logic [PREG_W-1:0]       w_ps2    [WIDTH];
    logic [PREG_W-1:0]       w_old_pd [WIDTH];
    logic [WIDTH-1:0]        w_push_en;
    logic [PTR_W-1:0]        w_push_idx [WIDTH];

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= FL_DEPTH) s = s - FL_DEPTH;
        return PTR_W'(s);
    endfunction

    always_comb begin
        w_n_alloc = 0;
        for (int k = 0; k < WIDTH; k++) begin
            w_alloc[k] = in_valid[k] && (in_rd[k*5 +: 5] != 5'd0);
            if (w_alloc[k]) w_n_alloc = w_n_alloc + 1;
        end
    end

    assign in_ready = ((r_out_valid == '0) || out_ready) && (32'(r_count) >= w_n_alloc);
    assign w_accept = in_ready && (|in_valid);
    assign w_n_pop  = w_accept ? w_n_alloc : 0;

    // Younger lanes see the destinations allocated by older lanes in the same group.
    always_comb begin : rename_comb
        int unsigned off;
        logic [4:0]  rd, rs1, rs2;
        off = 0;
        for (int k = 0; k < WIDTH; k++) begin
            rd  = in_rd[k*5 +: 5];
            rs1 = in_rs1[k*5 +: 5];
            rs2 = in_rs2[k*5 +: 5];
            w_pd[k]     = w_alloc[k] ? r_fl[ptr_add(r_head, off)] : '0;
            w_ps1[k]    = (rs1 == 5'd0) ? '0 : r_rat[rs1];
            w_ps2[k]    = (rs2 == 5'd0) ? '0 : r_rat[rs2];
            w_old_pd[k] = (rd == 5'd0) ? '0 : r_rat[rd];
            for (int j = 0; j < WIDTH; j++) begin
                if (j < k && w_alloc[j]) begin
                    if (in_rd[j*5 +: 5] == rs1) w_ps1[k] = w_pd[j];
                    if (in_rd[j*5 +: 5] == rs2) w_ps2[k] = w_pd[j];
                    if (in_rd[j*5 +: 5] == rd)  w_old_pd[k] = w_pd[j];
                end
            end
            if (w_alloc[k]) off = off + 1;
        end
    end

    // Slots freed by this cycle's pops are available to this cycle's pushes.
    always_comb begin : retire_comb
        int unsigned space;
        space    = FL_DEPTH - 32'(r_count) + w_n_pop;
        w_n_push = 0;
        for (int k = 0; k < WIDTH; k++) begin
            w_push_idx[k] = ptr_add(r_tail, w_n_push);
            w_push_en[k]  = rt_valid[k] && (rt_preg[k*PREG_W +: PREG_W] != '0)
                            && (w_n_push < space);
            if (w_push_en[k]) w_n_push = w_n_push + 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) r_rat[i] <= PREG_W'(i);
            for (int i = 0; i < FL_DEPTH; i++) r_fl[i] <= PREG_W'(ARCH_REGS + i);
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= CNT_W'(FL_DEPTH);
            r_out_valid  <= '0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_out_pd     <= '0;
            r_out_ps1    <= '0;
            r_out_ps2    <= '0;
            r_out_old_pd <= '0;
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                if (w_push_en[k]) r_fl[w_push_idx[k]] <= rt_preg[k*PREG_W +: PREG_W];
            end
            r_head  <= ptr_add(r_head, w_n_pop);
            r_tail  <= ptr_add(r_tail, w_n_push);
            r_count <= CNT_W'(32'(r_count) - w_n_pop + w_n_push);
            if (w_accept) begin
                // Ascending lane order makes the youngest writer of an rd win.
                for (int k = 0; k < WIDTH; k++) begin
                    if (w_alloc[k]) r_rat[in_rd[k*5 +: 5]] <= w_pd[k];
                    r_out_pd[k*PREG_W +: PREG_W]     <= w_pd[k];
                    r_out_ps1[k*PREG_W +: PREG_W]    <= w_ps1[k];
                    r_out_ps2[k*PREG_W +: PREG_W]    <= w_ps2[k];
                    r_out_old_pd[k*PREG_W +: PREG_W] <= w_old_pd[k];
                end
                r_out_valid <= in_valid;
                r_out_instr <= in_instr;
                r_out_pc    <= in_pc;
            end else if (out_ready) begin
                r_out_valid <= '0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_instr  = r_out_instr;
    assign out_pc     = r_out_pc;
    assign out_pd     = r_out_pd;
    assign out_ps1    = r_out_ps1;
    assign out_ps2    = r_out_ps2;
    assign out_old_pd = r_out_old_pd;
    assign free_count = r_count;

endmodule

// File: doc/rename_stage_n.md
Name: rename_stage_n

Overview:
- Parametrised N-wide register-rename stage. It sits between decode and dispatch and generalises the fixed dual-issue front end.
- Holds the RAT (arch→phys map) and a circular free list of physical registers.
- Renames up to WIDTH instructions per cycle, including intra-group dependencies.
- Stalls on free-list exhaustion or downstream backpressure, and recycles old physical registers on retire.

Parameters:
- WIDTH, 2, instructions renamed per cycle (lanes).
- ARCH_REGS, 32, architectural registers; x0 is hardwired and never renamed.
- PHYS_REGS, 64, physical registers; must be greater than ARCH_REGS.
- PREG_W, 6, physical register index width; must equal clog2(PHYS_REGS).
- PC_W, 8, PC width carried through.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  WIDTH  per-lane instruction valid; lane 0 is oldest.
- in_instr  in  WIDTH*32  raw instruction per lane, passed through.
- in_pc  in  WIDTH*PC_W  PC per lane.
- in_rd  in  WIDTH*5  destination arch register.
- in_rs1  in  WIDTH*5  source 1 arch register.
- in_rs2  in  WIDTH*5  source 2 arch register.
- in_ready  out  1  group accepted this cycle when in_ready && |in_valid.
- out_valid  out  WIDTH  renamed lane valid.
- out_instr  out  WIDTH*32  registered copy of in_instr.
- out_pc  out  WIDTH*PC_W  registered copy of in_pc.
- out_pd  out  WIDTH*PREG_W  new physical destination (0 if rd==0).
- out_ps1  out  WIDTH*PREG_W  physical source 1.
- out_ps2  out  WIDTH*PREG_W  physical source 2.
- out_old_pd  out  WIDTH*PREG_W  previous mapping of rd, for ROB.
- out_ready  in  1  downstream accepts the output group.
- rt_valid  in  WIDTH  retire lane frees a physical register.
- rt_preg  in  WIDTH*PREG_W  physical register to free (an old_pd).
- free_count  out  clog2(PHYS_REGS-ARCH_REGS+1)  entries in the free list.

Behaviour:
- Reset (async, any time, including mid-stall):
  - RAT[i]=i for all i.
  - Free list holds ARCH_REGS..PHYS_REGS-1 in ascending order; head=0, tail=0 (wrapped), full.
  - free_count=PHYS_REGS-ARCH_REGS.
  - out_valid=0; all other outputs 0.
- Allocating lane: in_valid[k] && in_rd[k]!=0. Let A = number of allocating lanes.
- in_ready = (out_valid==0 || out_ready) && (free_count >= A). Combinational. Groups are all-or-nothing: no partial acceptance.
- On accept:
  - Lanes allocate in order 0..WIDTH-1, popping consecutive head entries.
  - Source mapping: ps for lane k = pd of the highest lane j<k with matching rd!=0; otherwise RAT[rs]. Source x0 always maps to 0.
  - old_pd for lane k = pd of the highest lane j<k with the same rd; otherwise RAT[rd]. For rd==0, old_pd=0.
  - RAT write: the last lane writing a given rd wins.
  - Results appear on outputs the cycle after accept (latency 1).
- Output hold:
  - If out_valid!=0 && !out_ready, outputs stay stable and in_ready=0.
  - If out_ready with no new accept, out_valid clears to 0.
- Invalid lanes: out_valid=0, no allocation, no RAT update.
- Retire: each rt_valid lane with rt_preg!=0 pushes at tail in lane order. rt_preg==0 is ignored.
- Simultaneous accept and retire: free_count_next = free_count - A + F. A retired register is not allocatable in the same cycle.
- Pointers: head and tail wrap modulo PHYS_REGS-ARCH_REGS.
- Overflow: a push that would exceed capacity is dropped and is a checker error. free_count never exceeds capacity.

Test Plan:
- Reset, then lane0 add x5,x1,x2 and lane1 add x6,x3,x4, out_ready=1 -> next cycle pd=32,33; ps=1,2 / 3,4; old_pd=5,6; free_count=30.
- Lane0 writes x7, lane1 reads x7 and writes x7 -> lane1 ps1=32; lane1 old_pd=32; RAT[7]=33.
- rd=x0 on both lanes -> pd=0, old_pd=0, free_count unchanged, RAT unchanged.
- Drain until free_count=1, then present a group with A=2 -> in_ready=0, outputs unchanged. Assert rt_valid=01 with rt_preg=5 -> free_count=2 next cycle; group then accepted and pops the next head entry, then 5.
- out_ready=0 for 3 cycles while valid -> out_* stable and in_ready=0; release -> next group appears one cycle later.
- Assert rst mid-stall with out_valid=11 -> out_valid=0 immediately, free_count=32, RAT identity; next rename of x1 gives pd=32.
